// File: rtl/apb_pkg.sv
// Shared types for the APB request front-end: FSM states and the queued request payload.
package apb_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/apb_req_fifo.sv
// Synchronous request FIFO; full/empty are registered so a pop never frees a slot in the same cycle.
module apb_req_fifo
    import apb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  req_t                   push_data,
    input  logic                   pop,
    output req_t                   pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    req_t             mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;
    logic [LVL_W-1:0] level_d;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rptr];

    always_comb begin
        level_d = level + LVL_W'(do_push) - LVL_W'(do_pop);
    end

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            level <= level_d;
            full  <= (level_d == LVL_W'(DEPTH));
            empty <= (level_d == '0);
        end
    end

endmodule

// File: rtl/apb_req_queue.sv
// APB master front-end: queues CPU requests, issues one at a time, returns one response each with timeout.
module apb_req_queue
    import apb_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic                   req_wr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   sel_out,
    output logic [ADDR_W-1:0]      addr_out,
    output logic                   wr_out,
    output logic [DATA_W-1:0]      data_out,
    input  logic                   ready_in,
    input  logic [DATA_W-1:0]      rdata_in,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    req_t              out_q;
    req_t              out_d;
    logic              sel_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rdata_d;
    logic              err_d;
    logic              pop;
    logic              full;
    logic              empty;
    req_t              head;
    req_t              push_data;

    assign push_data = req_t'{addr: req_addr, wr: req_wr, wdata: req_wdata};
    assign req_ready = ~full;
    assign addr_out  = out_q.addr;
    assign wr_out    = out_q.wr;
    assign data_out  = out_q.wdata;

    apb_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_valid),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // Next-state and registered-output decode; ready_in wins over timeout in the same cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        sel_d       = sel_out;
        rsp_valid_d = rsp_valid;
        rdata_d     = rsp_rdata;
        err_d       = rsp_err;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    out_d   = head;
                    sel_d   = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (ready_in) begin
                    rdata_d     = out_q.wr ? '0 : rdata_in;
                    err_d       = 1'b0;
                    sel_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d     = '0;
                    err_d       = 1'b1;
                    sel_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_q     <= '0;
            sel_out   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            sel_out   <= sel_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rdata_d;
            rsp_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_apb_req_queue.sv
// Bench for apb_req_queue: request table plus scoreboard, slave and response-sink models.
module tb_apb_req_queue;

    typedef struct {
        logic [11:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] slv_rdata;
        int unsigned delay;
        int unsigned hold;
        int unsigned exp_sel;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_addr = '0;
    logic        req_wr = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        sel_out;
    logic [11:0] addr_out;
    logic        wr_out;
    logic [31:0] data_out;
    logic        ready_in = 1'b0;
    logic [31:0] rdata_in = '0;
    logic [2:0]  level;

    vec_t        tbl [8];
    vec_t        t3 [6];
    vec_t        sb [$];
    vec_t        issued [$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    apb_req_queue #(
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wr    (req_wr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .sel_out   (sel_out),
        .addr_out  (addr_out),
        .wr_out    (wr_out),
        .data_out  (data_out),
        .ready_in  (ready_in),
        .rdata_in  (rdata_in),
        .level     (level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [11:0] a, input logic w, input logic [31:0] wd,
                                input logic [31:0] sr, input int unsigned d, input int unsigned h,
                                input int unsigned es, input logic [31:0] er, input logic ee);
        vec_t v;
        v.addr = a; v.wr = w; v.wdata = wd; v.slv_rdata = sr; v.delay = d;
        v.hold = h; v.exp_sel = es; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic push(input vec_t v);
        int unsigned g = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (!req_ready && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) check("push_ready_timeout", 32'(req_ready), 1);
        req_addr  = v.addr;
        req_wr    = v.wr;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        sb.push_back(v);
        issued.push_back(v);
    endtask

    task automatic push_done();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned c = 0;
        while ((sb.size() != 0 || rsp_valid) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("drain_sb_empty", 32'(sb.size()), 0);
        check("drain_issued_empty", 32'(issued.size()), 0);
    endtask

    // Slave model and response sink, both acting on the falling edge.
    int unsigned sel_cnt = 0;
    logic        prev_sel = 1'b0;
    logic        bus_bad = 1'b0;
    logic        rsp_active = 1'b0;
    int unsigned hold_left = 0;
    logic [31:0] cap_rdata = '0;
    logic        cap_err = 1'b0;
    logic        stable_bad = 1'b0;
    vec_t        sv;
    vec_t        mv;

    always @(negedge clk) begin
        if (!rst) begin
            sel_cnt    = 0;
            prev_sel   = 1'b0;
            ready_in   = 1'b0;
            rsp_active = 1'b0;
            rsp_ready  = 1'b0;
            hold_left  = 0;
        end else begin
            if (sel_out) begin
                if (!prev_sel) begin
                    sel_cnt = 0;
                    bus_bad = 1'b0;
                    check("sel_has_request", 32'(issued.size() != 0), 1);
                end
                sel_cnt++;
                if (issued.size() != 0) begin
                    sv = issued[0];
                    if (addr_out !== sv.addr || wr_out !== sv.wr || data_out !== sv.wdata)
                        bus_bad = 1'b1;
                    ready_in = (sv.delay == 0) ? 1'b1 : (sel_cnt >= 2 && sel_cnt - 2 == sv.delay);
                    rdata_in = sv.slv_rdata;
                end else begin
                    ready_in = 1'b1;
                end
            end else begin
                if (prev_sel && issued.size() != 0) begin
                    sv = issued.pop_front();
                    check("sel_cycles", sel_cnt, sv.exp_sel);
                    check("bus_stable", 32'(bus_bad), 0);
                end
                ready_in = 1'($urandom_range(0, 1));
                rdata_in = $urandom;
            end
            prev_sel = sel_out;

            if (rsp_valid) begin
                if (!rsp_active) begin
                    rsp_active = 1'b1;
                    stable_bad = 1'b0;
                    cap_rdata  = rsp_rdata;
                    cap_err    = rsp_err;
                    hold_left  = (sb.size() != 0) ? sb[0].hold : 0;
                end else if (rsp_rdata !== cap_rdata || rsp_err !== cap_err || sel_out !== 1'b0) begin
                    stable_bad = 1'b1;
                end
                if (hold_left != 0) begin
                    hold_left--;
                    rsp_ready = 1'b0;
                end else begin
                    rsp_ready  = 1'b1;
                    rsp_active = 1'b0;
                    check("rsp_expected", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        mv = sb.pop_front();
                        check("rsp_rdata", rsp_rdata, mv.exp_rdata);
                        check("rsp_err", 32'(rsp_err), 32'(mv.exp_err));
                        if (mv.hold != 0) check("rsp_hold_stable", 32'(stable_bad), 0);
                    end
                end
            end else begin
                rsp_ready = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lat;
        tbl[0] = mk(12'h104, 1'b1, 32'hA5A5_0001, 32'h1111_2222,   0, 0,  2, 32'h0,         1'b0);
        tbl[1] = mk(12'h208, 1'b0, 32'h0,         32'hDEAD_BEEF,   3, 0,  5, 32'hDEAD_BEEF, 1'b0);
        tbl[2] = mk(12'h30C, 1'b0, 32'h0,         32'h5555_AAAA, 100, 0, 17, 32'h0,         1'b1);
        tbl[3] = mk(12'h010, 1'b0, 32'h0,         32'h0BAD_F00D,   1, 0,  3, 32'h0BAD_F00D, 1'b0);
        tbl[4] = mk(12'h3FC, 1'b0, 32'h0,         32'hCAFE_0015,  15, 0, 17, 32'hCAFE_0015, 1'b0);
        tbl[5] = mk(12'h420, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF,   2, 0,  4, 32'h0,         1'b0);
        tbl[6] = mk(12'h55C, 1'b0, 32'h0,         32'h0000_0042,   0, 5,  2, 32'h0000_0042, 1'b0);
        tbl[7] = mk(12'h660, 1'b1, 32'hFEED_0007, 32'h7777_7777, 100, 0, 17, 32'h0,         1'b1);

        t3[0] = mk(12'h700, 1'b0, 32'h0,         32'h0000_0700,  10, 0, 12, 32'h0000_0700, 1'b0);
        t3[1] = mk(12'h704, 1'b1, 32'h0000_0704, 32'h0000_9999,   0, 0,  2, 32'h0,         1'b0);
        t3[2] = mk(12'h708, 1'b0, 32'h0,         32'h0000_0708,   0, 0,  2, 32'h0000_0708, 1'b0);
        t3[3] = mk(12'h70C, 1'b0, 32'h0,         32'h0000_070C,   2, 0,  4, 32'h0000_070C, 1'b0);
        t3[4] = mk(12'h710, 1'b1, 32'h0000_0710, 32'h0000_8888,   0, 0,  2, 32'h0,         1'b0);
        t3[5] = mk(12'h714, 1'b0, 32'h0,         32'h0000_0714,   0, 0,  2, 32'h0000_0714, 1'b0);

        #3;
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_level", 32'(level), 0);
        check("rst_sel_out", 32'(sel_out), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_addr_out", 32'(addr_out), 0);
        @(negedge clk);
        #2 rst = 1'b1;

        // Table vectors streamed back to back; order, timing and data checked by the models.
        for (int i = 0; i < 8; i++) begin
            push(tbl[i]);
        end
        push_done();
        wait_drain();

        // Single request, ready in first WAIT cycle: rsp_valid on the fourth edge counting the accept edge.
        push(tbl[0]);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("min_latency_negedges", lat, 4);
        wait_drain();

        // Fill the FIFO behind a slow transfer.
        push(t3[0]);
        push(t3[1]);
        push(t3[2]);
        check("level_push_pop_same_cycle", 32'(level), 1);
        push(t3[3]);
        push(t3[4]);
        @(negedge clk);
        check("level_full", 32'(level), 4);
        check("req_ready_full", 32'(req_ready), 0);
        @(negedge clk);
        check("level_still_full", 32'(level), 4);
        push(t3[5]);
        push_done();
        wait_drain();

        // Asynchronous reset in the middle of WAIT with two requests queued.
        push(mk(12'h800, 1'b0, 32'h0, 32'h0000_0800, 30, 0, 17, 32'h0000_0800, 1'b0));
        push(mk(12'h804, 1'b0, 32'h0, 32'h0000_0804, 0, 0, 2, 32'h0000_0804, 1'b0));
        push(mk(12'h808, 1'b0, 32'h0, 32'h0000_0808, 0, 0, 2, 32'h0000_0808, 1'b0));
        push_done();
        repeat (3) @(negedge clk);
        check("mid_wait_sel", 32'(sel_out), 1);
        check("mid_wait_level", 32'(level), 2);
        #2 rst = 1'b0;
        #1;
        check("async_rst_sel", 32'(sel_out), 0);
        check("async_rst_level", 32'(level), 0);
        check("async_rst_req_ready", 32'(req_ready), 1);
        sb.delete();
        issued.delete();
        @(negedge clk);
        @(negedge clk);
        check("rst_no_response", 32'(rsp_valid), 0);
        #2 rst = 1'b1;
        push(mk(12'h90C, 1'b0, 32'h0, 32'h1357_9BDF, 1, 0, 3, 32'h1357_9BDF, 1'b0));
        push_done();
        wait_drain();
        check("final_level", 32'(level), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
